// File: rtl/wb_soc_reg_slave_pkg.sv
`default_nettype none
// ============================================================================
// Package     : wb_soc_reg_slave_pkg
// Description : Register map of the Wishbone SoC register slave. Shared by
//               the RTL, the peripherals that embed the block and the
//               firmware header generator.
// Contents    : byte offsets of the four registers, STATUS bit positions and
//               a small decode helper.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_soc_reg_slave_pkg;

    // Byte offsets within the 16-byte register window
    localparam logic [3:0] REG_ADDR_OFF     = 4'h0;
    localparam logic [3:0] REG_STATUS_OFF   = 4'h4;
    localparam logic [3:0] REG_IRQ_STAT_OFF = 4'h8;
    localparam logic [3:0] REG_IRQ_EN_OFF   = 4'hC;

    // STATUS register bit positions
    localparam int STATUS_INIT_BIT = 0;
    localparam int STATUS_IRQ_BIT  = 1;

    // Word-aligned register offset from a byte address (low two bits dropped)
    function automatic logic [3:0] reg_offset(input logic [3:0] byte_adr);
        return {byte_adr[3:2], 2'b00};
    endfunction

endpackage : wb_soc_reg_slave_pkg
`default_nettype wire

// File: rtl/wb_soc_reg_slave_sync_edge_detect.sv
`default_nettype none
// ============================================================================
// Module      : wb_soc_reg_slave_sync_edge_detect
// Description : Two-flop synchroniser followed by a rising-edge detector.
//               A level held high produces exactly one single-cycle pulse.
// Ports       : p_clk      - destination clock
//               p_resetn   - asynchronous active-low reset
//               async_i    - asynchronous input level
//               pulse_o    - one-cycle pulse on synchronised rising edge
// Revision    : 1.0 - initial release
// ============================================================================
module wb_soc_reg_slave_sync_edge_detect (
    input  logic p_clk,
    input  logic p_resetn,
    input  logic async_i,
    output logic pulse_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge p_clk or negedge p_resetn) begin
        if (!p_resetn) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    // Combinational so the consumer can register the event on the third edge
    assign pulse_o = sync_q & ~prev_q;

endmodule : wb_soc_reg_slave_sync_edge_detect
`default_nettype wire

// File: rtl/wb_soc_reg_slave.sv
`default_nettype none
// ============================================================================
// Module      : wb_soc_reg_slave
// Description : Wishbone classic slave register block. Holds a 32-bit
//               configuration word for a peripheral datapath and a maskable,
//               sticky interrupt raised by the peripheral.
// Ports       : p_clk / p_resetn      - bus clock, async active-low reset
//               raise_irq             - interrupt request from peripheral
//               irq                   - level interrupt to the CPU
//               module_register       - contents of the ADDR register
//               initialized           - sticky, set by first ADDR write
//               p_wb_reg_*            - Wishbone classic slave port
// Registers   : 0x0 ADDR (RW, byte lanes), 0x4 STATUS (RO),
//               0x8 IRQ_STAT (W1C), 0xC IRQ_EN (RW bit0)
// Revision    : 1.0 - initial release
// ============================================================================
module wb_soc_reg_slave
    import wb_soc_reg_slave_pkg::*;
(
    input  logic        p_clk,
    input  logic        p_resetn,
    input  logic        raise_irq,
    output logic        irq,
    output logic [31:0] module_register,
    output logic        initialized,
    input  logic [31:0] p_wb_reg_DAT_I,
    output logic [31:0] p_wb_reg_DAT_O,
    input  logic [31:0] p_wb_reg_ADR_I,
    output logic        p_wb_reg_ACK_O,
    input  logic        p_wb_reg_CYC_I,
    output logic        p_wb_reg_ERR_O,
    input  logic        p_wb_reg_LOCK_I,
    output logic        p_wb_reg_RTY_O,
    input  logic [3:0]  p_wb_reg_SEL_I,
    input  logic        p_wb_reg_STB_I,
    input  logic        p_wb_reg_WE_I
);

    logic [31:0] addr_q,     addr_d;
    logic        init_q,     init_d;
    logic        irq_stat_q, irq_stat_d;
    logic        irq_en_q,   irq_en_d;
    logic        ack_q,      ack_d;
    logic        err_q,      err_d;
    logic [31:0] dat_o_q,    dat_o_d;

    logic        w_set_pulse;
    logic        w_req;
    logic        w_misaligned;
    logic        w_wr;
    logic        w_w1c;
    logic [31:0] w_rdata;
    logic        w_unused_inputs;

    wb_soc_reg_slave_sync_edge_detect u_raise_sync (
        .p_clk    (p_clk),
        .p_resetn (p_resetn),
        .async_i  (raise_irq),
        .pulse_o  (w_set_pulse)
    );

    // Blocking on our own termination yields one termination every two
    // cycles under a continuously asserted strobe.
    assign w_req        = p_wb_reg_CYC_I & p_wb_reg_STB_I & ~ack_q & ~err_q;
    assign w_misaligned = |p_wb_reg_ADR_I[1:0];
    assign w_wr         = w_req & ~w_misaligned & p_wb_reg_WE_I;

    always_comb begin
        addr_d  = addr_q;
        init_d  = init_q;
        irq_en_d = irq_en_q;
        w_w1c   = 1'b0;
        w_rdata = 32'h0;
        unique case (reg_offset(p_wb_reg_ADR_I[3:0]))
            REG_ADDR_OFF: begin
                w_rdata = addr_q;
                if (w_wr) begin
                    for (int i = 0; i < 4; i++) begin
                        if (p_wb_reg_SEL_I[i]) begin
                            addr_d[8*i +: 8] = p_wb_reg_DAT_I[8*i +: 8];
                        end
                    end
                    if (|p_wb_reg_SEL_I) begin
                        init_d = 1'b1;
                    end
                end
            end
            REG_STATUS_OFF: begin
                w_rdata[STATUS_INIT_BIT] = init_q;
                w_rdata[STATUS_IRQ_BIT]  = irq_stat_q;
            end
            REG_IRQ_STAT_OFF: begin
                w_rdata[0] = irq_stat_q;
                w_w1c      = w_wr & p_wb_reg_SEL_I[0] & p_wb_reg_DAT_I[0];
            end
            REG_IRQ_EN_OFF: begin
                w_rdata[0] = irq_en_q;
                if (w_wr && p_wb_reg_SEL_I[0]) begin
                    irq_en_d = p_wb_reg_DAT_I[0];
                end
            end
            default: ;
        endcase
    end

    // A new event in the same cycle as a software clear must not be lost
    assign irq_stat_d = w_set_pulse | (irq_stat_q & ~w_w1c);

    assign ack_d   = w_req & ~w_misaligned;
    assign err_d   = w_req &  w_misaligned;
    assign dat_o_d = (w_req && !w_misaligned && !p_wb_reg_WE_I) ? w_rdata : 32'h0;

    always_ff @(posedge p_clk or negedge p_resetn) begin
        if (!p_resetn) begin
            addr_q     <= 32'h0;
            init_q     <= 1'b0;
            irq_stat_q <= 1'b0;
            irq_en_q   <= 1'b1;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            dat_o_q    <= 32'h0;
        end else begin
            addr_q     <= addr_d;
            init_q     <= init_d;
            irq_stat_q <= irq_stat_d;
            irq_en_q   <= irq_en_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            dat_o_q    <= dat_o_d;
        end
    end

    assign irq             = irq_stat_q & irq_en_q;
    assign module_register = addr_q;
    assign initialized     = init_q;
    assign p_wb_reg_DAT_O  = dat_o_q;
    assign p_wb_reg_ACK_O  = ack_q;
    assign p_wb_reg_ERR_O  = err_q;
    assign p_wb_reg_RTY_O  = 1'b0;

    // Only the low address nibble is decoded; LOCK has no meaning here
    assign w_unused_inputs = ^{p_wb_reg_ADR_I[31:4], p_wb_reg_LOCK_I};

endmodule : wb_soc_reg_slave
`default_nettype wire

// File: tb/tb_wb_soc_reg_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_soc_reg_slave
// Description : Self-checking bench for wb_soc_reg_slave. Directed register
//               map scenarios followed by random bus traffic and random
//               interrupt requests, compared against a register-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_soc_reg_slave;

    logic        p_clk = 1'b0;
    logic        p_resetn = 1'b0;
    logic        raise_irq = 1'b0;
    logic        irq;
    logic [31:0] module_register;
    logic        initialized;
    logic [31:0] dat_i = '0;
    logic [31:0] dat_o;
    logic [31:0] adr_i = '0;
    logic        ack_o;
    logic        cyc_i = 1'b0;
    logic        err_o;
    logic        lock_i = 1'b0;
    logic        rty_o;
    logic [3:0]  sel_i = '0;
    logic        stb_i = 1'b0;
    logic        we_i = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    wb_soc_reg_slave dut (
        .p_clk           (p_clk),
        .p_resetn        (p_resetn),
        .raise_irq       (raise_irq),
        .irq             (irq),
        .module_register (module_register),
        .initialized     (initialized),
        .p_wb_reg_DAT_I  (dat_i),
        .p_wb_reg_DAT_O  (dat_o),
        .p_wb_reg_ADR_I  (adr_i),
        .p_wb_reg_ACK_O  (ack_o),
        .p_wb_reg_CYC_I  (cyc_i),
        .p_wb_reg_ERR_O  (err_o),
        .p_wb_reg_LOCK_I (lock_i),
        .p_wb_reg_RTY_O  (rty_o),
        .p_wb_reg_SEL_I  (sel_i),
        .p_wb_reg_STB_I  (stb_i),
        .p_wb_reg_WE_I   (we_i)
    );

    always #5 p_clk = ~p_clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    logic [31:0] mdl_addr = '0;
    logic        mdl_init = 1'b0;
    logic        mdl_en   = 1'b1;
    logic        mdl_stat = 1'b0;
    logic        clr_req  = 1'b0;
    // raise_irq as sampled at the previous three clock edges
    logic [2:0]  hist     = '0;
    logic        mon_en   = 1'b0;

    // An event lands when the request was seen high two edges ago and low
    // three edges ago (two synchroniser stages plus the status flop).
    always @(posedge p_clk or negedge p_resetn) begin
        if (!p_resetn) begin
            hist     <= '0;
            mdl_stat <= 1'b0;
        end else begin
            hist     <= {hist[1:0], raise_irq};
            mdl_stat <= (hist[1] & ~hist[2]) | (mdl_stat & ~clr_req);
        end
    end

    always @(negedge p_clk) begin
        if (mon_en) begin
            check_eq("irq_level", {31'h0, irq}, {31'h0, mdl_stat & mdl_en});
        end
    end

    function automatic logic [31:0] mdl_read(input logic [3:0] off);
        case (off)
            4'h0:    return mdl_addr;
            4'h4:    return {30'h0, mdl_stat, mdl_init};
            4'h8:    return {31'h0, mdl_stat};
            default: return {31'h0, mdl_en};
        endcase
    endfunction

    // One complete Wishbone access: request, termination cycle, idle cycle
    task automatic bus(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                       input logic [31:0] dat, output logic [31:0] rd);
        logic        bad;
        logic [31:0] exp_rd;
        logic [3:0]  off;
        @(negedge p_clk);
        bad    = (adr[1:0] != 2'b00);
        off    = {adr[3:2], 2'b00};
        exp_rd = bad ? 32'h0 : mdl_read(off);
        clr_req = !bad && we && off == 4'h8 && sel[0] && dat[0];
        cyc_i = 1'b1; stb_i = 1'b1; we_i = we; adr_i = adr; sel_i = sel; dat_i = dat;
        @(posedge p_clk);
        #1;
        cyc_i = 1'b0; stb_i = 1'b0; clr_req = 1'b0;
        if (!bad && we) begin
            for (int i = 0; i < 4; i++) begin
                if (sel[i]) mdl_addr[8*i +: 8] = (off == 4'h0) ? dat[8*i +: 8] : mdl_addr[8*i +: 8];
            end
            if (off == 4'h0 && sel != 4'h0) mdl_init = 1'b1;
            if (off == 4'hC && sel[0]) mdl_en = dat[0];
        end
        rd = dat_o;
        check_eq("ack", {31'h0, ack_o}, {31'h0, !bad});
        check_eq("err", {31'h0, err_o}, {31'h0, bad});
        if (bad || !we) check_eq("rdata", dat_o, exp_rd);
        check_eq("module_register", module_register, mdl_addr);
        check_eq("initialized", {31'h0, initialized}, {31'h0, mdl_init});
        @(posedge p_clk);
        #1;
        check_eq("term_single", {30'h0, ack_o, err_o}, 32'h0);
        check_eq("dat_idle", dat_o, 32'h0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge p_clk);
    endtask

    logic [31:0] rd;
    logic [31:0] saved;

    initial begin
        // ---------------- reset ----------------
        repeat (3) @(negedge p_clk);
        check_eq("rst_outs", {27'h0, ack_o, err_o, rty_o, irq, initialized}, 32'h0);
        check_eq("rst_dat_o", dat_o, 32'h0);
        check_eq("rst_modreg", module_register, 32'h0);
        p_resetn = 1'b1;
        mon_en   = 1'b1;

        bus(1'b0, 32'hC, 4'hF, 32'h0, rd);
        check_eq("rst_irq_en", rd, 32'h1);
        bus(1'b0, 32'h0, 4'hF, 32'h0, rd);
        check_eq("rst_addr", rd, 32'h0);

        // ---------------- ADDR writes ----------------
        bus(1'b1, 32'h0, 4'hF, 32'h41000000, rd);
        check_eq("addr_full", module_register, 32'h41000000);
        check_eq("init_set", {31'h0, initialized}, 32'h1);
        bus(1'b0, 32'h4, 4'hF, 32'h0, rd);
        check_eq("status_init", rd, 32'h1);
        bus(1'b1, 32'h0, 4'h1, 32'h000000AA, rd);
        check_eq("addr_lane0", module_register, 32'h410000AA);

        // ---------------- interrupt latency and W1C ----------------
        @(negedge p_clk);
        raise_irq = 1'b1;
        @(posedge p_clk); @(posedge p_clk); #1;
        check_eq("irq_before_3rd", {31'h0, irq}, 32'h0);
        @(posedge p_clk); #1;
        check_eq("irq_at_3rd", {31'h0, irq}, 32'h1);
        bus(1'b0, 32'h8, 4'hF, 32'h0, rd);
        check_eq("irq_stat_read", rd, 32'h1);
        bus(1'b1, 32'h8, 4'h1, 32'h1, rd);
        check_eq("irq_w1c", {31'h0, irq}, 32'h0);
        idle(5);
        check_eq("irq_level_no_reset", {31'h0, irq}, 32'h0);
        raise_irq = 1'b0;
        idle(4);

        // ---------------- masking ----------------
        bus(1'b1, 32'hC, 4'hF, 32'h0, rd);
        raise_irq = 1'b1;
        idle(2);
        raise_irq = 1'b0;
        idle(4);
        check_eq("irq_masked", {31'h0, irq}, 32'h0);
        bus(1'b0, 32'h4, 4'hF, 32'h0, rd);
        check_eq("status_raw", rd, 32'h3);
        bus(1'b1, 32'hC, 4'hF, 32'h1, rd);
        check_eq("irq_unmasked", {31'h0, irq}, 32'h1);
        bus(1'b1, 32'h8, 4'hF, 32'hFFFFFFFF, rd);
        idle(4);

        // ---------------- set beats simultaneous W1C ----------------
        bus(1'b1, 32'h8, 4'h1, 32'h1, rd);
        idle(4);
        raise_irq = 1'b1;   // at a falling edge; set lands on the 3rd rising edge
        @(negedge p_clk);
        bus(1'b1, 32'h8, 4'h1, 32'h1, rd);
        check_eq("set_wins", {31'h0, irq}, 32'h1);
        raise_irq = 1'b0;
        bus(1'b1, 32'h8, 4'h1, 32'h1, rd);
        idle(4);

        // ---------------- misaligned accesses ----------------
        saved = module_register;
        bus(1'b0, 32'h2, 4'hF, 32'h0, rd);
        bus(1'b1, 32'h1, 4'hF, 32'hFFFFFFFF, rd);
        check_eq("err_no_change", module_register, saved);

        // ---------------- continuous strobe ----------------
        @(negedge p_clk);
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = 32'hC; sel_i = 4'hF;
        for (int c = 0; c < 4; c++) begin
            @(posedge p_clk); #1;
            check_eq("cont_ack", {31'h0, ack_o}, {31'h0, (c % 2) == 0});
            if (c == 2) begin
                cyc_i = 1'b0; stb_i = 1'b0;
            end
        end

        // ---------------- random traffic ----------------
        for (int it = 0; it < 300; it++) begin
            logic [31:0] a;
            int op;
            op = $urandom_range(0, 5);
            a  = $urandom();
            case (op)
                0, 1: bus(1'b1, {a[31:4], a[3:2], 2'b00}, 4'($urandom()), $urandom(), rd);
                2:    bus(1'b0, {a[31:4], a[3:2], 2'b00}, 4'hF, 32'h0, rd);
                3:    bus(a[0], {a[31:2], (a[1:0] == 2'b00) ? 2'b01 : a[1:0]}, 4'hF, $urandom(), rd);
                4:    begin @(negedge p_clk); raise_irq = a[4]; end
                default: idle($urandom_range(1, 4));
            endcase
        end
        raise_irq = 1'b0;
        idle(4);

        // ---------------- reset in the middle of an access ----------------
        @(negedge p_clk);
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; adr_i = 32'h0; sel_i = 4'hF; dat_i = 32'h12345678;
        #2;
        p_resetn = 1'b0;
        mdl_addr = '0; mdl_init = 1'b0; mdl_en = 1'b1;
        #1;
        check_eq("rst_async", {29'h0, ack_o, irq, initialized}, 32'h0);
        @(posedge p_clk); #1;
        check_eq("rst_no_ack", {30'h0, ack_o, err_o}, 32'h0);
        check_eq("rst_mid_modreg", module_register, 32'h0);
        @(negedge p_clk);
        cyc_i = 1'b0; stb_i = 1'b0;
        p_resetn = 1'b1;
        bus(1'b0, 32'hC, 4'hF, 32'h0, rd);
        check_eq("rst_mid_en", rd, 32'h1);

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_wb_soc_reg_slave
`default_nettype wire
